gate_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for a 2-input combinational gate (default: NAND).
//  On start it drives all four {a,b} vectors for LOOPS passes, waits SETTLE cycles per vector,

---
 rtl/gate_bist_pkg.sv | 20 ++
 rtl/gate_bist_ctrl_timer.sv | 30 +++
 rtl/gate_bist_ctrl.sv | 130 +++++++++++++
 tb/tb_gate_bist_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST sequencer.
package gate_bist_pkg;

    // Sequencer states; ST_ prefix keeps them apart from the SETTLE parameter.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    localparam int NUM_VEC = 4;

    // Truth tables indexed by {a,b}: bit0={0,0} .. bit3={1,1}.
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_bist_ctrl_timer.sv
// Settle timer: reloads to SETTLE-1 while load is high, counts down while en is high,
// and flags expired during the last enabled cycle of the settle window.
module bist_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(SETTLE) + 1;

    logic [TW-1:0] count;

    // Reload outside the settle window, count down inside it, stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(SETTLE - 1);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a 2-input combinational gate: walks all four {a,b} vectors
// for LOOPS passes, samples gate_y after SETTLE cycles and accumulates mismatches.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] EXP_TT = TT_NAND,
    parameter int         SETTLE = 2,
    parameter int         LOOPS  = 1,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             gate_y,
    output logic             gate_a,
    output logic             gate_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_mask,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int                LOOP_W    = $clog2(LOOPS) + 1;
    localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);

    state_t            state;
    logic [1:0]        idx;
    logic [LOOP_W-1:0] loop;
    logic              settle_done;
    logic              timer_load;
    logic              timer_en;

    // Mismatch counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The timer is held loaded everywhere except SETTLE, so each entry starts a fresh window.
    always_comb begin
        timer_en   = (state == ST_SETTLE);
        timer_load = !timer_en;
    end

    bist_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (settle_done)
    );

    // Sequencer FSM with registered gate drives and result registers; abort overrides any busy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            loop      <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'b0000;
            fail_cnt  <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            // Partial fail_mask/fail_cnt are kept so the aborted run can still be inspected.
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        fail_mask <= 4'b0000;
                        fail_cnt  <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        idx       <= 2'd0;
                        loop      <= '0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (gate_y != EXP_TT[idx]) begin
                        fail_mask[idx] <= 1'b1;
                        fail_cnt       <= sat_inc(fail_cnt);
                    end
                    if ((idx == 2'd3) && (loop == LAST_LOOP)) begin
                        state <= ST_FINISH;
                    end else begin
                        idx              <= idx + 2'd1;
                        {gate_a, gate_b} <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            loop <= loop + 1'b1;
                        end
                        state <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    // fail_mask already holds the last SAMPLE update here.
                    done   <= 1'b1;
                    pass   <= (fail_mask == 4'b0000);
                    busy   <= 1'b0;
                    gate_a <= 1'b0;
                    gate_b <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: three instances (LOOPS=1, LOOPS=3, CNT_W=2/LOOPS=2),
// each driven by a gate model whose truth table is chosen per run.
module tb_gate_bist_ctrl;

    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam int         SET     = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       start_v;
    logic [2:0]       abort_v;
    logic [2:0]       y_v;
    logic [2:0]       ga_v;
    logic [2:0]       gb_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0]       pass_v;
    logic [2:0][3:0]  mask_v;
    logic [2:0][3:0]  tt_v;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
    logic [1:0]       cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate under test models: y is the chosen truth table looked up by {a,b}.
    assign y_v[0] = tt_v[0][{ga_v[0], gb_v[0]}];
    assign y_v[1] = tt_v[1][{ga_v[1], gb_v[1]}];
    assign y_v[2] = tt_v[2][{ga_v[2], gb_v[2]}];

    gate_bist_ctrl #(.EXP_TT(NAND_TT), .SETTLE(SET), .LOOPS(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .gate_y(y_v[0]),
        .gate_a(ga_v[0]), .gate_b(gb_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .fail_mask(mask_v[0]), .fail_cnt(cnt0)
    );

    gate_bist_ctrl #(.EXP_TT(NAND_TT), .SETTLE(SET), .LOOPS(3), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .gate_y(y_v[1]),
        .gate_a(ga_v[1]), .gate_b(gb_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .fail_mask(mask_v[1]), .fail_cnt(cnt1)
    );

    gate_bist_ctrl #(.EXP_TT(NAND_TT), .SETTLE(SET), .LOOPS(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .gate_y(y_v[2]),
        .gate_a(ga_v[2]), .gate_b(gb_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .fail_mask(mask_v[2]), .fail_cnt(cnt2)
    );

    function automatic int loops_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 2) ? 3 : 255;
    endfunction

    function automatic logic [7:0] cnt_of(input int k);
        return (k == 0) ? cnt0 : ((k == 1) ? cnt1 : {6'd0, cnt2});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full run on instance k with gate truth table tt; optional start pulse mid-run.
    task automatic run(input int k, input logic [3:0] tt, input bit pulse, input string tag);
        int         lat;
        int         c;
        int         n;
        bit         vec_ok;
        logic [3:0] mism;
        lat    = 4 * loops_of(k) * (SET + 1) + 1;
        mism   = tt ^ NAND_TT;
        n      = $countones(mism) * loops_of(k);
        if (n > cmax_of(k)) n = cmax_of(k);
        tt_v[k] = tt;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy_v[k]), 32'd1);
        chk({tag, "_done_clr"}, 32'(done_v[k]), 32'd0);
        vec_ok = 1'b1;
        c      = 0;
        while (c < lat + 20) begin
            @(posedge clk);
            #1;
            c++;
            start_v[k] = (pulse && (c == 5)) ? 1'b1 : 1'b0;
            if ((c < lat - 1) && ({ga_v[k], gb_v[k]} !== 2'((c / (SET + 1)) % 4)))
                vec_ok = 1'b0;
            if (done_v[k] === 1'b1) break;
        end
        start_v[k] = 1'b0;
        chk({tag, "_latency"}, 32'(c), 32'(lat));
        chk({tag, "_vectors"}, 32'(vec_ok), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy_v[k]), 32'd0);
        chk({tag, "_gates"}, 32'({ga_v[k], gb_v[k]}), 32'd0);
        chk({tag, "_pass"}, 32'(pass_v[k]), 32'(mism == 4'b0000));
        chk({tag, "_mask"}, 32'(mask_v[k]), 32'(mism));
        chk({tag, "_cnt"}, 32'(cnt_of(k)), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        bit         found;
        logic [3:0] tt;
        rst_n   = 1'b0;
        start_v = '0;
        abort_v = '0;
        tt_v    = {3{NAND_TT}};
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_v[i]), 32'd0);
            chk("rst_done_pass", 32'({done_v[i], pass_v[i]}), 32'd0);
            chk("rst_gates", 32'({ga_v[i], gb_v[i]}), 32'd0);
            chk("rst_mask_cnt", 32'({mask_v[i], cnt_of(i)}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run(0, NAND_TT, 1'b0, "good");
        run(0, 4'b1111, 1'b0, "stuck1");
        run(1, 4'b0000, 1'b0, "stuck0_l3");
        run(2, 4'b0000, 1'b0, "sat");
        run(0, NAND_TT, 1'b1, "midstart");

        // start and abort together in IDLE: not started, done stays sticky
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("sa_idle_busy", 32'(busy_v[0]), 32'd0);
        chk("sa_idle_done", 32'(done_v[0]), 32'd1);

        // abort once vector 2 is being driven; vectors 0 and 1 already sampled
        tt_v[0] = 4'b0110;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if ({ga_v[0], gb_v[0]} === 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach_idx2", 32'(found), 32'd1);
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_done_pass", 32'({done_v[0], pass_v[0]}), 32'd0);
        chk("abort_gates", 32'({ga_v[0], gb_v[0]}), 32'd0);
        chk("abort_mask", 32'(mask_v[0]), 32'((4'b0110 ^ NAND_TT) & 4'b0011));
        chk("abort_cnt", 32'(cnt0), 32'($countones((4'b0110 ^ NAND_TT) & 4'b0011)));
        run(0, NAND_TT, 1'b0, "after_abort");

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            k  = int'($urandom_range(0, 2));
            tt = 4'($urandom_range(0, 15));
            run(k, tt, bit'($urandom_range(0, 1)), $sformatf("rnd%0d_k%0d_tt%0h", r, k, tt));
        end

        // asynchronous reset in the middle of a failing run
        tt_v[0] = 4'b0110;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_rst_mask", 32'(mask_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy_done_pass", 32'({busy_v[0], done_v[0], pass_v[0]}), 32'd0);
        chk("midrst_gates", 32'({ga_v[0], gb_v[0]}), 32'd0);
        chk("midrst_mask_cnt", 32'({mask_v[0], cnt0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, NAND_TT, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
